mips_trace_buf: RTL and testbench

Synthesizable commit-trace buffer for the MIPS pipeline. It captures register-file writes (W stage) and data-memory writes (M stage) as timestamped trace records. Records go into a parametrised FIFO and drain one per cycle over a valid/ready port to a host or debug UART. It replaces simulation-only write printing with a hardware-observable event stream, adds per-channel filtering and r0 suppression, and counts dropped events on overflow.

---
 rtl/mips_trace_buf.sv | 127 ++++++++++++
 tb/tb_mips_trace_buf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buf.sv
// mips_trace_buf: captures GPR (W stage) and DM (M stage) writes as cycle-stamped
// records in a FIFO drained over a valid/ready port, with per-channel filtering and drop counting.
`default_nettype none

module mips_trace_buf #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       gpr_wr,
    input  logic [4:0]                 gpr_waddr,
    input  logic [31:0]                gpr_wd,
    input  logic [31:0]                instr_w,
    input  logic                       dm_wr,
    input  logic [31:0]                dm_addr,
    input  logic [31:0]                dm_din,
    input  logic [31:0]                instr_m,
    input  logic [1:0]                 en_mask,
    input  logic                       skip_r0,
    input  logic                       flush,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [1:0]                 tr_kind,
    output logic [31:0]                tr_instr,
    output logic [31:0]                tr_addr,
    output logic [31:0]                tr_data,
    output logic [31:0]                tr_cycle,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } rec_t;

    rec_t              mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       level_q, level_d, free;
    logic [31:0]       cycle_q;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]    drop_sum;
    logic              g_ev, d_ev, push_g, push_d, pop;
    logic [1:0]        n_drop;
    rec_t              rec_g, rec_d, head;

    always_comb begin
        g_ev   = gpr_wr & en_mask[0] & ~(skip_r0 & (gpr_waddr == 5'd0));
        d_ev   = dm_wr & en_mask[1];
        free   = DEPTH_L - level_q;
        push_g = 1'b0;
        push_d = 1'b0;
        // With one slot left the older W-stage write wins; DM only fits if GPR is idle.
        if (free >= (AW+1)'(2)) begin
            push_g = g_ev;
            push_d = d_ev;
        end else if (free == (AW+1)'(1)) begin
            push_g = g_ev;
            push_d = d_ev & ~g_ev;
        end
        n_drop   = {1'b0, g_ev & ~push_g} + {1'b0, d_ev & ~push_d};
        pop      = tr_valid & tr_ready;
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);

        rec_g = '{kind: 2'b01, instr: instr_w, addr: {27'd0, gpr_waddr},
                  data: gpr_wd, cyc: cycle_q};
        rec_d = '{kind: 2'b10, instr: instr_m, addr: dm_addr,
                  data: dm_din, cyc: cycle_q};

        wptr_d  = wptr_q + AW'(push_g) + AW'(push_d);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + (AW+1)'(push_g) + (AW+1)'(push_d) - (AW+1)'(pop);
        drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            drop_d  = drop_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cycle_q <= '0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            cycle_q <= cycle_q + 32'd1;
            drop_q  <= drop_d;
        end
    end

    // Storage is deliberately left unreset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_g) mem_q[wptr_q] <= rec_g;
            if (push_d) mem_q[wptr_q + AW'(push_g)] <= rec_d;
        end
    end

    always_comb begin
        head     = mem_q[rptr_q];
        tr_valid = (level_q != '0);
        tr_kind  = tr_valid ? head.kind  : 2'b00;
        tr_instr = tr_valid ? head.instr : 32'd0;
        tr_addr  = tr_valid ? head.addr  : 32'd0;
        tr_data  = tr_valid ? head.data  : 32'd0;
        tr_cycle = tr_valid ? head.cyc   : 32'd0;
        drop_cnt = drop_q;
        level    = level_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_trace_buf.sv
// Scoreboard bench for mips_trace_buf: directed stimulus queues expected records,
// a negedge monitor compares every handshaken record against the queue head.
`default_nettype none

module tb_mips_trace_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gpr_wr = 1'b0, dm_wr = 1'b0, skip_r0 = 1'b0, flush = 1'b0, tr_ready = 1'b0;
    logic [4:0]  gpr_waddr = '0;
    logic [31:0] gpr_wd = '0, instr_w = '0, dm_addr = '0, dm_din = '0, instr_m = '0;
    logic [1:0]  en_mask = 2'b11;
    logic        tr_valid;
    logic [1:0]  tr_kind;
    logic [31:0] tr_instr, tr_addr, tr_data, tr_cycle;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    mips_trace_buf #(.DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd), .instr_w(instr_w),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .instr_m(instr_m),
        .en_mask(en_mask), .skip_r0(skip_r0), .flush(flush),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
        .tr_instr(tr_instr), .tr_addr(tr_addr), .tr_data(tr_data), .tr_cycle(tr_cycle),
        .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  k;
        logic [31:0] i, a, d, c;
    } rec_t;

    rec_t        q[$];
    int          n_vec = 0, n_err = 0;
    logic        mon_en = 1'b1;
    logic [31:0] tb_cyc;

    // Independent model of the free-running cycle stamp.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rec(input logic [1:0] k, input logic [31:0] i, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] c);
        rec_t r;
        r.k = k; r.i = i; r.a = a; r.d = d; r.c = c;
        q.push_back(r);
    endtask

    task automatic drv_gpr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] i);
        gpr_wr = 1'b1; gpr_waddr = a; gpr_wd = d; instr_w = i;
    endtask

    task automatic drv_dm(input logic [31:0] a, input logic [31:0] d, input logic [31:0] i);
        dm_wr = 1'b1; dm_addr = a; dm_din = d; instr_m = i;
    endtask

    task automatic idle();
        gpr_wr = 1'b0; dm_wr = 1'b0; flush = 1'b0;
    endtask

    // Monitor: every accepted record must match the oldest expected record.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tr_valid && tr_ready) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_rec: got kind %0d data 0x%08h, expected none", tr_kind, tr_data);
                end else begin
                    r = q.pop_front();
                    chk("mon_kind",  {30'd0, tr_kind}, {30'd0, r.k});
                    chk("mon_instr", tr_instr, r.i);
                    chk("mon_addr",  tr_addr,  r.a);
                    chk("mon_data",  tr_data,  r.d);
                    chk("mon_cycle", tr_cycle, r.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        repeat (3) step();
        chk("rst_valid", {31'd0, tr_valid}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_drop",  {16'd0, drop_cnt}, 32'd0);
        chk("rst_kind",  {30'd0, tr_kind}, 32'd0);
        chk("rst_cycle", tr_cycle, 32'd0);
        rst_n = 1'b1;
        step();

        // Single GPR write, held by back-pressure, then popped.
        s = tb_cyc;
        drv_gpr(5'd5, 32'h1234, 32'h20A51234);
        exp_rec(2'b01, 32'h20A51234, 32'd5, 32'h1234, s);
        step(); idle();
        for (int c = 0; c < 4; c++) begin
            chk("t1_valid", {31'd0, tr_valid}, 32'd1);
            chk("t1_kind",  {30'd0, tr_kind}, 32'd1);
            chk("t1_addr",  tr_addr, 32'd5);
            chk("t1_data",  tr_data, 32'h1234);
            chk("t1_instr", tr_instr, 32'h20A51234);
            chk("t1_cycle", tr_cycle, s);
            chk("t1_level", {27'd0, level}, 32'd1);
            if (c < 3) step();
        end
        tr_ready = 1'b1;
        step();
        chk("t1_level_pop", {27'd0, level}, 32'd0);

        // Dual event: GPR first, DM next, same stamp.
        s = tb_cyc;
        drv_gpr(5'd7, 32'hAAAA, 32'h11111111);
        drv_dm(32'h1000, 32'hBBBB, 32'h22222222);
        exp_rec(2'b01, 32'h11111111, 32'd7, 32'hAAAA, s);
        exp_rec(2'b10, 32'h22222222, 32'h1000, 32'hBBBB, s);
        step(); idle();
        chk("t2_level2", {27'd0, level}, 32'd2);
        step(); step();
        chk("t2_level0", {27'd0, level}, 32'd0);
        chk("t2_q_empty", q.size(), 32'd0);

        // Filtering: r0 skip and DM channel disabled.
        skip_r0 = 1'b1;
        drv_gpr(5'd0, 32'hDEAD, 32'h0);
        step(); idle();
        chk("t3_r0_level", {27'd0, level}, 32'd0);
        en_mask = 2'b01;
        drv_dm(32'h40, 32'hBEEF, 32'h0);
        step(); idle();
        chk("t3_dm_level", {27'd0, level}, 32'd0);
        chk("t3_dm_drop",  {16'd0, drop_cnt}, 32'd0);
        en_mask = 2'b11; skip_r0 = 1'b0; tr_ready = 1'b0;

        // Overflow: 15 GPR, then dual events at the boundary.
        for (int i = 0; i < 15; i++) begin
            drv_gpr(5'(i + 1), 32'h100 + i, 32'h1000 + i);
            exp_rec(2'b01, 32'h1000 + i, i + 1, 32'h100 + i, tb_cyc);
            step();
        end
        drv_gpr(5'd20, 32'hD1, 32'h3000);
        drv_dm(32'h2000, 32'hD2, 32'h4000);
        exp_rec(2'b01, 32'h3000, 32'd20, 32'hD1, tb_cyc);
        step(); idle();
        chk("t4_level_full", {27'd0, level}, 32'd16);
        chk("t4_drop1", {16'd0, drop_cnt}, 32'd1);
        drv_gpr(5'd21, 32'hE1, 32'h5000);
        drv_dm(32'h2004, 32'hE2, 32'h6000);
        step(); idle();
        chk("t4_drop3", {16'd0, drop_cnt}, 32'd3);
        chk("t4_level_hold", {27'd0, level}, 32'd16);
        tr_ready = 1'b1;
        repeat (16) step();
        chk("t4_drained", {27'd0, level}, 32'd0);
        chk("t4_q_empty", q.size(), 32'd0);
        tr_ready = 1'b0;

        // Flush at full with dual event and ready.
        for (int i = 0; i < 16; i++) begin
            drv_gpr(5'd3, 32'h500 + i, 32'h7000 + i);
            step();
        end
        idle();
        chk("t5_full", {27'd0, level}, 32'd16);
        mon_en = 1'b0;
        flush = 1'b1; tr_ready = 1'b1;
        drv_gpr(5'd9, 32'hF1, 32'h0);
        drv_dm(32'h3000, 32'hF2, 32'h0);
        step(); idle(); tr_ready = 1'b0;
        chk("t5_level", {27'd0, level}, 32'd0);
        chk("t5_valid", {31'd0, tr_valid}, 32'd0);
        chk("t5_drop",  {16'd0, drop_cnt}, 32'd3);
        mon_en = 1'b1;

        // Cycle stamp keeps running across a flush.
        tr_ready = 1'b1;
        drv_gpr(5'd11, 32'h77, 32'h8000);
        exp_rec(2'b01, 32'h8000, 32'd11, 32'h77, tb_cyc);
        step(); idle(); step();
        chk("t5_post_q", q.size(), 32'd0);
        tr_ready = 1'b0;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 7; i++) begin
            drv_gpr(5'd4, 32'h900 + i, 32'h9000 + i);
            step();
        end
        idle();
        chk("t6_level7", {27'd0, level}, 32'd7);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, tr_valid}, 32'd0);
        chk("t6_level", {27'd0, level}, 32'd0);
        chk("t6_drop",  {16'd0, drop_cnt}, 32'd0);
        chk("t6_data",  tr_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        s = tb_cyc;
        drv_gpr(5'd6, 32'h66, 32'hA000);
        exp_rec(2'b01, 32'hA000, 32'd6, 32'h66, s);
        step(); idle();
        chk("t6_cycle_small", tr_cycle, 32'd1);
        tr_ready = 1'b1;
        step();
        chk("t6_q_empty", q.size(), 32'd0);
        chk("t6_level_end", {27'd0, level}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
